// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment formatter: segment patterns ([0:6] = a..g, active-low),
// FSM states and the display range limits.
package seg_pkg;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_MINUS = 7'b1111110;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_R     = 7'b1111010;

  // Largest magnitudes that fit in eight digits, or seven digits plus a minus sign
  localparam logic [31:0] POS_LIMIT = 32'd99999999;
  localparam logic [31:0] NEG_LIMIT = 32'd9999999;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_ENCODE
  } state_e;

endpackage

// File: rtl/seg7_digit_encode.sv
// Combinational BCD nibble to active-low seven-segment pattern; non-decimal codes show blank.
module seg7_digit_encode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_value_formatter.sv
// Signed value to eight seven-segment digits via a one-bit-per-clock double-dabble engine.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros and float the minus sign next to the number.
module seg_value_formatter
  import seg_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [0:6]       digit0,
  output logic [0:6]       digit1,
  output logic [0:6]       digit2,
  output logic [0:6]       digit3,
  output logic [0:6]       digit4,
  output logic [0:6]       digit5,
  output logic [0:6]       digit6,
  output logic [0:6]       digit7
);

  localparam int CNT_W = $clog2(NBITS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] mag_q, mag_d, mag_in;
  logic [31:0]      bcd_q, bcd_d;
  logic [30:0]      bcd_adj;
  logic             sign_q, sign_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [0:6]       digit_q [8];
  logic [0:6]       digit_d [8];
  logic [0:6]       enc_pat [8];
  logic [0:6]       fmt_pat [8];

  for (genvar g = 0; g < 8; g++) begin : g_enc
    seg7_digit_encode u_enc (
      .bcd (bcd_q[4*g +: 4]),
      .seg (enc_pat[g])
    );
  end

  assign mag_in = value[NBITS-1] ? (~value + 1'b1) : value;

  // The top nibble's carry-out is dropped: anything that large is shown as an error anyway
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 7; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    bcd_adj[30:28] = bcd_q[30:28] + ((bcd_q[31:28] >= 4'd5) ? 3'd3 : 3'd0);
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 1; i < 8; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      fmt_pat[i] = (i > int'(msd)) ? SEG_BLANK : enc_pat[i];
    end
    if (sign_q && (msd != 3'd7)) fmt_pat[int'(msd) + 1] = SEG_MINUS;
    if (ovf_pend_q) begin
      for (int i = 0; i < 8; i++) fmt_pat[i] = SEG_BLANK;
      fmt_pat[2] = SEG_E;
      fmt_pat[1] = SEG_R;
      fmt_pat[0] = SEG_R;
    end
  end
`else
  // Negatives never reach eight digits, so digit7 is always a zero the minus can replace
  always_comb begin
    for (int i = 0; i < 8; i++) fmt_pat[i] = enc_pat[i];
    if (sign_q) fmt_pat[7] = SEG_MINUS;
    if (ovf_pend_q) begin
      for (int i = 0; i < 8; i++) fmt_pat[i] = SEG_BLANK;
      fmt_pat[2] = SEG_E;
      fmt_pat[1] = SEG_R;
      fmt_pat[0] = SEG_R;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    for (int i = 0; i < 8; i++) digit_d[i] = digit_q[i];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d     = value[NBITS-1];
          mag_d      = mag_in;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = value[NBITS-1] ? (mag_in > NBITS'(NEG_LIMIT))
                                      : (mag_in > NBITS'(POS_LIMIT));
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        bcd_d = {bcd_adj, mag_q[NBITS-1]};
        mag_d = {mag_q[NBITS-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NBITS - 1)) state_d = ST_ENCODE;
      end
      ST_ENCODE: begin
        for (int i = 0; i < 8; i++) digit_d[i] = fmt_pat[i];
        done_d  = 1'b1;
        ovf_d   = ovf_pend_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < 8; i++) digit_q[i] <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      for (int i = 0; i < 8; i++) digit_q[i] <= digit_d[i];
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];
  assign digit4 = digit_q[4];
  assign digit5 = digit_q[5];
  assign digit6 = digit_q[6];
  assign digit7 = digit_q[7];

endmodule
